pp_seq_multiplier: RTL and testbench

Parametrised sequential multiplier that generalises the fixed 8x8 partial-product AND array.
- Each cycle it generates K partial-product rows (A & B[bit]) and shift-accumulates them.
- A WIDTH x WIDTH product completes in WIDTH/K cycles behind a valid/ready handshake.
- It sits between operand producers and product consumers in the multiplier datapath and replaces the full combinational AND array where area matters.

---
 rtl/mult_pkg.sv | 15 +
 rtl/pp_and_row.sv | 12 +
 rtl/pp_seq_multiplier.sv | 139 +++++++++++++
 tb/tb_pp_seq_multiplier.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential partial-product multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mult_state_e;

  // Counter width for a given slice count; at least one bit so K == WIDTH still elaborates.
  function automatic int cnt_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/pp_and_row.sv
// One partial-product row: the multiplicand gated by a single multiplier bit.
module pp_and_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b,
  output logic [WIDTH-1:0] row
);

  assign row = a & {WIDTH{b}};

endmodule

// File: rtl/pp_seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier consuming K multiplier bits per cycle behind valid/ready.
// Define MULT_SIGNED_EN to add the signed_i port and two's-complement operand handling.
module pp_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] Out,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MULT_SIGNED_EN
  ,
  input  logic               signed_i
`endif
);

  localparam int N  = WIDTH / K;
  localparam int CW = cnt_width(N);
  localparam int PW = 2 * WIDTH;

  generate
    if ((WIDTH < 2) || (K < 1) || (WIDTH % K != 0)) begin : g_bad_cfg
      $error("pp_seq_multiplier: K must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  mult_state_e      state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_sr;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rows [K];
  logic [PW-1:0]    slice_sum;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last_slice;

  for (genvar j = 0; j < K; j++) begin : g_rows
    pp_and_row #(.WIDTH(WIDTH)) u_row (
      .a  (a_reg),
      .b  (b_sr[j]),
      .row(rows[j])
    );
  end

  assign last_slice = (count == CW'(N - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    slice_sum = '0;
    for (int j = 0; j < K; j++) begin
      slice_sum = slice_sum + (PW'(rows[j]) << j);
    end
    acc_next = acc + (slice_sum << (K * int'(count)));
  end

`ifdef MULT_SIGNED_EN
  logic neg;
  logic sign_in;

  // Most-negative input maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  always_comb begin
    a_mag   = (signed_i && A[WIDTH-1]) ? (~A + 1'b1) : A;
    b_mag   = (signed_i && B[WIDTH-1]) ? (~B + 1'b1) : B;
    sign_in = signed_i && (A[WIDTH-1] ^ B[WIDTH-1]);
    result  = neg ? (~acc_next + 1'b1) : acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      neg <= sign_in;
    end
  end
`else
  always_comb begin
    a_mag  = A;
    b_mag  = B;
    result = acc_next;
  end
`endif

  // NOTE: datapath registers are reset along with control so an aborted product leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Out       <= '0;
      count     <= '0;
      acc       <= '0;
      a_reg     <= '0;
      b_sr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a_mag;
            b_sr     <= b_mag;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          b_sr  <= b_sr >> K;
          count <= count + 1'b1;
          if (last_slice) begin
            Out       <= result;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Returning through IDLE keeps an out handshake and a new accept in separate cycles.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_seq_multiplier.sv
// Randomised self-checking bench: K=1 and K=4 instances of the 8-bit multiplier against a plain arithmetic model.
module tb_pp_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  A, B;
  logic        in_valid;
  logic        out_ready;
  logic        sel;
  logic        in_valid1, in_valid4;
  logic        in_ready1, in_ready4, out_valid1, out_valid4;
  logic [15:0] out1, out4;
  logic        in_ready_s, out_valid_s;
  logic [15:0] out_s;
`ifdef MULT_SIGNED_EN
  logic        signed_i;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign in_valid1   = in_valid & ~sel;
  assign in_valid4   = in_valid & sel;
  assign in_ready_s  = sel ? in_ready4 : in_ready1;
  assign out_valid_s = sel ? out_valid4 : out_valid1;
  assign out_s       = sel ? out4 : out1;

  pp_seq_multiplier #(.WIDTH(8), .K(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .Out      (out1),
    .out_valid(out_valid1),
    .out_ready(out_ready)
`ifdef MULT_SIGNED_EN
    ,
    .signed_i (signed_i)
`endif
  );

  pp_seq_multiplier #(.WIDTH(8), .K(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .Out      (out4),
    .out_valid(out_valid4),
    .out_ready(out_ready)
`ifdef MULT_SIGNED_EN
    ,
    .signed_i (signed_i)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Golden product straight from integer arithmetic.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    int pa, pb;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    return 16'(pa * pb);
  endfunction

  // One full transaction on the selected instance; hold>0 applies backpressure and stray in_valid pulses.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input int hold);
    int          n;
    int          lat;
    logic        busy_rdy;
    logic [15:0] exp;
    n        = sel ? 2 : 8;
    exp      = ref_mul(a, b, s);
    busy_rdy = 1'b0;
    check("in_ready_idle", 32'(in_ready_s), 32'd1);
    A         = a;
    B         = b;
`ifdef MULT_SIGNED_EN
    signed_i  = s;
`endif
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    step();
    in_valid = (hold > 0);
    A        = 8'($urandom);
    B        = 8'($urandom);
    lat      = 0;
    while (!out_valid_s && lat < 40) begin
      if (in_ready_s) busy_rdy = 1'b1;
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'(n));
    check("in_ready_busy", 32'(busy_rdy), 32'd0);
    check("product", 32'(out_s), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      A        = 8'($urandom);
      step();
      check("hold_out", 32'(out_s), 32'(exp));
      check("hold_valid", 32'(out_valid_s), 32'd1);
      check("hold_in_ready", 32'(in_ready_s), 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("drop_valid", 32'(out_valid_s), 32'd0);
    check("back_idle", 32'(in_ready_s), 32'd1);
    if (hold > 0) begin
      step();
      check("no_stray_accept", 32'(in_ready_s), 32'd1);
      check("out_kept", 32'(out_s), 32'(exp));
    end
  endtask

  initial begin
    rst       = 1'b1;
    A         = '0;
    B         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sel       = 1'b0;
`ifdef MULT_SIGNED_EN
    signed_i  = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      check("rst_in_ready", 32'(in_ready_s), 32'd1);
      check("rst_out_valid", 32'(out_valid_s), 32'd0);
      check("rst_out", 32'(out_s), 32'd0);
    end

    sel = 1'b0;
    run_op(8'd255, 8'd255, 1'b0, 0);
    sel = 1'b1;
    run_op(8'd13, 8'd11, 1'b0, 0);
    for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom), 1'b0, 0);
    sel = 1'b0;
    for (int i = 0; i < 8; i++) run_op(8'($urandom), 8'($urandom), 1'b0, 0);

    // Backpressure with stray in_valid during BUSY and DONE.
    sel = 1'b1;
    run_op(8'($urandom), 8'($urandom), 1'b0, 5);
    sel = 1'b0;
    run_op(8'($urandom), 8'($urandom), 1'b0, 5);

    // Abort mid-BUSY after the third slice.
    sel      = 1'b0;
    A        = 8'd200;
    B        = 8'd201;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready_s), 32'd1);
    check("abort_out_valid", 32'(out_valid_s), 32'd0);
    check("abort_out", 32'(out_s), 32'd0);
    run_op(8'd2, 8'd3, 1'b0, 0);

`ifdef MULT_SIGNED_EN
    sel = 1'b0;
    run_op(8'h80, 8'h80, 1'b1, 0);
    run_op(8'hFF, 8'h01, 1'b1, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    for (int i = 0; i < 8; i++) run_op(8'($urandom), 8'($urandom), 1'($urandom), 0);
    sel = 1'b1;
    run_op(8'h80, 8'h7F, 1'b1, 0);
    for (int i = 0; i < 12; i++) run_op(8'($urandom), 8'($urandom), 1'($urandom), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
